// File: rtl/ds1620_poll_ctrl.sv
// DS1620 transaction sequencer: one-time configuration, then convert/read cycles
// triggered by a poll timer or by requesters, with coalesced acknowledgement.
module ds1620_poll_ctrl #(
    parameter int unsigned POLL_DIV  = 1_000_000,
    parameter int unsigned CONV_WAIT = 750_000,
    parameter int unsigned TIMEOUT   = 4096,
    parameter logic [7:0]  CFG_BYTE  = 8'h02
) (
    input  logic       CLK_IN,
    input  logic       CLR_N,
    input  logic [1:0] REQ,
    output logic [1:0] ACK,
    output logic [8:0] TEMP,
    output logic       TEMP_VALID,
    output logic       ERR,
    output logic       ENG_START,
    output logic [7:0] ENG_CMD,
    output logic       ENG_WR,
    output logic [7:0] ENG_WDATA,
    output logic       ENG_RD,
    input  logic       ENG_BUSY,
    input  logic       ENG_DONE,
    input  logic [8:0] ENG_RDATA
);

    localparam int PW = $clog2(POLL_DIV + 1);
    localparam int WW = $clog2(CONV_WAIT + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    localparam logic [PW-1:0] POLL_RELOAD = PW'(POLL_DIV - 1);
    localparam logic [WW-1:0] WAIT_LAST   = WW'(CONV_WAIT - 1);
    localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT - 1);

    localparam logic [7:0] CMD_WRITE_CFG = 8'h0C;
    localparam logic [7:0] CMD_START_CNV = 8'hEE;
    localparam logic [7:0] CMD_READ_TEMP = 8'hAA;

    typedef enum logic [2:0] {
        ST_CFG, ST_IDLE, ST_CONV, ST_WAIT, ST_READ, ST_PUB
    } state_t;

    state_t          state_q, state_d;
    logic            launched_q, launched_d;
    logic            start_q, start_d;
    logic [7:0]      cmd_q, cmd_d;
    logic            wr_q, wr_d;
    logic [7:0]      wdata_q, wdata_d;
    logic            rd_q, rd_d;
    logic [WW-1:0]   wait_q, wait_d;
    logic [TW-1:0]   to_q, to_d;
    logic [PW-1:0]   poll_q, poll_d;
    logic            poll_pend_q, poll_pend_d;
    logic [1:0]      svc_q, svc_d;
    logic [8:0]      temp_q, temp_d;
    logic [1:0]      ack_q, ack_d;
    logic            tv_q, tv_d;
    logic            err_q, err_d;
    logic            done_ok, timed_out, poll_expire;

    always_comb begin
        // NOTE: every target is defaulted first so no branch can infer a latch.
        state_d     = state_q;
        launched_d  = launched_q;
        start_d     = 1'b0;
        cmd_d       = cmd_q;
        wr_d        = wr_q;
        wdata_d     = wdata_q;
        rd_d        = rd_q;
        wait_d      = wait_q;
        to_d        = to_q;
        svc_d       = svc_q;
        temp_d      = temp_q;
        ack_d       = 2'b00;
        tv_d        = 1'b0;
        err_d       = err_q;

        poll_expire = (poll_q == '0);
        poll_d      = poll_expire ? POLL_RELOAD : poll_q - 1'b1;
        poll_pend_d = poll_pend_q | poll_expire;

        // DONE only counts for a command this block actually launched.
        done_ok   = launched_q && ENG_DONE;
        timed_out = launched_q && !ENG_DONE && (to_q == TO_LAST);
        if (launched_q && !ENG_DONE)
            to_d = to_q + 1'b1;

        case (state_q)
            ST_CFG:  if (done_ok) state_d = ST_IDLE;
            ST_IDLE: if (poll_pend_q || (REQ != 2'b00)) begin
                         svc_d       = REQ;
                         poll_pend_d = 1'b0;
                         state_d     = ST_CONV;
                     end
            ST_CONV: if (done_ok) begin
                         state_d = ST_WAIT;
                         wait_d  = WAIT_LAST;
                     end
            ST_WAIT: if (wait_q == '0) state_d = ST_READ;
                     else              wait_d  = wait_q - 1'b1;
            ST_READ: if (done_ok) begin
                         temp_d  = ENG_RDATA;
                         ack_d   = svc_q;
                         tv_d    = 1'b1;
                         state_d = ST_PUB;
                     end
            ST_PUB:  begin
                         svc_d   = 2'b00;
                         state_d = ST_IDLE;
                     end
            default: state_d = ST_CFG;
        endcase

        if (timed_out) begin
            err_d   = 1'b1;
            svc_d   = 2'b00;
            state_d = (state_q == ST_CFG) ? ST_CFG : ST_IDLE;
        end

        if (done_ok || timed_out) begin
            launched_d = 1'b0;
            cmd_d      = 8'h00;
            wr_d       = 1'b0;
            wdata_d    = 8'h00;
            rd_d       = 1'b0;
        end

        // Launch on the edge that enters a command state, or the first idle-engine edge after.
        if (!launched_d && !ENG_BUSY &&
            (state_d == ST_CFG || state_d == ST_CONV || state_d == ST_READ)) begin
            start_d    = 1'b1;
            launched_d = 1'b1;
            to_d       = '0;
            cmd_d      = (state_d == ST_CFG)  ? CMD_WRITE_CFG :
                         (state_d == ST_CONV) ? CMD_START_CNV : CMD_READ_TEMP;
            wr_d       = (state_d == ST_CFG);
            wdata_d    = (state_d == ST_CFG) ? CFG_BYTE : 8'h00;
            rd_d       = (state_d == ST_READ);
        end
    end

    always_ff @(posedge CLK_IN or negedge CLR_N) begin
        if (!CLR_N) begin
            state_q     <= ST_CFG;
            launched_q  <= 1'b0;
            start_q     <= 1'b0;
            cmd_q       <= 8'h00;
            wr_q        <= 1'b0;
            wdata_q     <= 8'h00;
            rd_q        <= 1'b0;
            wait_q      <= '0;
            to_q        <= '0;
            poll_q      <= POLL_RELOAD;
            poll_pend_q <= 1'b0;
            svc_q       <= 2'b00;
            temp_q      <= 9'h000;
            ack_q       <= 2'b00;
            tv_q        <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            // NOTE: non-blocking so every register updates from the same pre-edge values.
            state_q     <= state_d;
            launched_q  <= launched_d;
            start_q     <= start_d;
            cmd_q       <= cmd_d;
            wr_q        <= wr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wait_q      <= wait_d;
            to_q        <= to_d;
            poll_q      <= poll_d;
            poll_pend_q <= poll_pend_d;
            svc_q       <= svc_d;
            temp_q      <= temp_d;
            ack_q       <= ack_d;
            tv_q        <= tv_d;
            err_q       <= err_d;
        end
    end

    assign ACK        = ack_q;
    assign TEMP       = temp_q;
    assign TEMP_VALID = tv_q;
    assign ERR        = err_q;
    assign ENG_START  = start_q;
    assign ENG_CMD    = cmd_q;
    assign ENG_WR     = wr_q;
    assign ENG_WDATA  = wdata_q;
    assign ENG_RD     = rd_q;

endmodule

// File: tb/tb_ds1620_poll_ctrl.sv
// Directed bench for ds1620_poll_ctrl with a fixed-latency serial engine model.
module tb_ds1620_poll_ctrl;

    localparam int ENG_L = 10;

    logic       CLK_IN = 1'b0;
    logic       CLR_N  = 1'b1;
    logic [1:0] REQ;
    logic [1:0] ACK;
    logic [8:0] TEMP;
    logic       TEMP_VALID;
    logic       ERR;
    logic       ENG_START;
    logic [7:0] ENG_CMD;
    logic       ENG_WR;
    logic [7:0] ENG_WDATA;
    logic       ENG_RD;
    logic       ENG_BUSY  = 1'b0;
    logic       ENG_DONE  = 1'b0;
    logic [8:0] ENG_RDATA = 9'h000;

    ds1620_poll_ctrl #(
        .POLL_DIV (50),
        .CONV_WAIT(20),
        .TIMEOUT  (100),
        .CFG_BYTE (8'h02)
    ) dut (
        .CLK_IN    (CLK_IN),
        .CLR_N     (CLR_N),
        .REQ       (REQ),
        .ACK       (ACK),
        .TEMP      (TEMP),
        .TEMP_VALID(TEMP_VALID),
        .ERR       (ERR),
        .ENG_START (ENG_START),
        .ENG_CMD   (ENG_CMD),
        .ENG_WR    (ENG_WR),
        .ENG_WDATA (ENG_WDATA),
        .ENG_RD    (ENG_RD),
        .ENG_BUSY  (ENG_BUSY),
        .ENG_DONE  (ENG_DONE),
        .ENG_RDATA (ENG_RDATA)
    );

    always #5 CLK_IN = ~CLK_IN;

    int cyc = 0;
    always @(posedge CLK_IN) cyc <= cyc + 1;

    // Engine model: DONE arrives ENG_L cycles after the strobe; READ can be made silent.
    logic [8:0] rdata   = 9'h000;
    logic       drop_aa = 1'b0;
    int         eng_cnt = 0;
    always @(negedge CLK_IN) begin
        ENG_DONE = 1'b0;
        if (ENG_START) begin
            if (!(drop_aa && ENG_CMD == 8'hAA)) begin
                ENG_BUSY = 1'b1;
                eng_cnt  = ENG_L;
            end
        end else if (ENG_BUSY) begin
            eng_cnt = eng_cnt - 1;
            if (eng_cnt == 0) begin
                ENG_BUSY  = 1'b0;
                ENG_DONE  = 1'b1;
                ENG_RDATA = rdata;
            end
        end
    end

    int ee_cnt = 0, aa_cnt = 0, ack_cnt = 0;
    always @(negedge CLK_IN) begin
        if (ENG_START && ENG_CMD == 8'hEE) ee_cnt++;
        if (ENG_START && ENG_CMD == 8'hAA) aa_cnt++;
        if (ACK != 2'b00) ack_cnt++;
    end

    int errors = 0, checks = 0;

    bit         found;
    logic [7:0] s_cmd, s_wdata;
    logic       s_wr, s_rd;
    int         s_at;
    logic [1:0] t_ack;
    logic [8:0] t_temp;
    logic       t_err;
    int         t_at;

    task automatic wait_strobe(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK_IN);
            if (ENG_START) begin
                got = 1'b1; s_cmd = ENG_CMD; s_wr = ENG_WR;
                s_wdata = ENG_WDATA; s_rd = ENG_RD; s_at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_tv(input int budget, output bit got);
        got = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge CLK_IN);
            if (TEMP_VALID) begin
                got = 1'b1; t_ack = ACK; t_temp = TEMP; t_err = ERR; t_at = cyc;
                break;
            end
        end
    endtask

    int rel, cfg_at, ee_at, aa_at, prev_tv, base_ee, base_aa, base_ack;

    initial begin
        REQ = 2'b00;
        rdata = 9'h032;
        #2 CLR_N = 1'b0;
        repeat (3) @(negedge CLK_IN);

        // Reset values
        checks++; assert (ACK === 2'b00) else begin errors++; $error("FAIL rst_ack: got %0h want 0", ACK); end
        checks++; assert (TEMP === 9'h000) else begin errors++; $error("FAIL rst_temp: got %0h want 0", TEMP); end
        checks++; assert ({TEMP_VALID, ERR, ENG_START} === 3'b000) else begin errors++; $error("FAIL rst_flags: got %0b want 000", {TEMP_VALID, ERR, ENG_START}); end
        checks++; assert ({ENG_CMD, ENG_WR, ENG_WDATA, ENG_RD} === 18'h0) else begin errors++; $error("FAIL rst_eng: got %0h want 0", {ENG_CMD, ENG_WR, ENG_WDATA, ENG_RD}); end

        // Init: configuration write comes first, on the first edge after reset
        CLR_N = 1'b1; rel = cyc;
        wait_strobe(5, found);
        checks++; assert (found) else begin errors++; $error("FAIL cfg_strobe: got none want strobe"); end
        checks++; assert ({s_cmd, s_wr, s_wdata, s_rd} === {8'h0C, 1'b1, 8'h02, 1'b0}) else begin errors++; $error("FAIL cfg_cmd: got %0h/%0b/%0h/%0b want 0c/1/02/0", s_cmd, s_wr, s_wdata, s_rd); end
        checks++; assert (s_at === rel + 1) else begin errors++; $error("FAIL cfg_first_edge: got %0d want %0d", s_at, rel + 1); end
        cfg_at = s_at;

        // Auto poll
        wait_strobe(200, found);
        checks++; assert (found && s_cmd === 8'hEE) else begin errors++; $error("FAIL poll_conv: got %0b/%0h want 1/ee", found, s_cmd); end
        checks++; assert ((s_at - cfg_at) >= ENG_L + 2) else begin errors++; $error("FAIL conv_after_cfg: got gap %0d want >= %0d", s_at - cfg_at, ENG_L + 2); end
        ee_at = s_at;
        wait_strobe(100, found);
        checks++; assert (found && s_cmd === 8'hAA && s_rd === 1'b1) else begin errors++; $error("FAIL poll_read: got %0b/%0h/%0b want 1/aa/1", found, s_cmd, s_rd); end
        checks++; assert (s_at - ee_at === ENG_L + 20 + 1) else begin errors++; $error("FAIL conv_wait_gap: got %0d want %0d", s_at - ee_at, ENG_L + 21); end
        aa_at = s_at;
        wait_tv(100, found);
        checks++; assert (found && t_temp === 9'h032 && t_ack === 2'b00) else begin errors++; $error("FAIL poll_pub1: got %0b/%0h/%0h want 1/032/0", found, t_temp, t_ack); end
        checks++; assert (t_at - aa_at === ENG_L + 1) else begin errors++; $error("FAIL read_to_pub: got %0d want %0d", t_at - aa_at, ENG_L + 1); end
        wait_tv(200, found);
        checks++; assert (found && t_temp === 9'h032 && t_ack === 2'b00) else begin errors++; $error("FAIL poll_pub2: got %0b/%0h/%0h want 1/032/0", found, t_temp, t_ack); end
        #1;
        checks++; assert (ack_cnt === 0) else begin errors++; $error("FAIL poll_no_ack: got %0d want 0", ack_cnt); end

        // Coalesce: both requesters share one conversion
        prev_tv = t_at; rdata = 9'h1CE; REQ = 2'b11;
        base_ee = ee_cnt; base_aa = aa_cnt;
        wait_tv(100, found);
        checks++; assert (found && t_ack === 2'b11 && t_temp === 9'h1CE) else begin errors++; $error("FAIL coalesce: got %0b/%0h/%0h want 1/3/1ce", found, t_ack, t_temp); end
        checks++; assert (t_at - prev_tv === 2 * ENG_L + 20 + 4) else begin errors++; $error("FAIL latency: got %0d want %0d", t_at - prev_tv, 2 * ENG_L + 24); end
        #1;
        checks++; assert ({ee_cnt - base_ee, aa_cnt - base_aa} === {32'd1, 32'd1}) else begin errors++; $error("FAIL single_pair: got %0d/%0d want 1/1", ee_cnt - base_ee, aa_cnt - base_aa); end

        // Late request: REQ[1] rising during WAIT waits for the next cycle
        REQ = 2'b01; rdata = 9'h0FA;
        wait_strobe(10, found);
        checks++; assert (found && s_cmd === 8'hEE) else begin errors++; $error("FAIL late_conv: got %0b/%0h want 1/ee", found, s_cmd); end
        repeat (15) @(negedge CLK_IN);
        REQ = 2'b11;
        wait_tv(100, found);
        checks++; assert (found && t_ack === 2'b01 && t_temp === 9'h0FA) else begin errors++; $error("FAIL late_first: got %0b/%0h/%0h want 1/1/0fa", found, t_ack, t_temp); end
        REQ = 2'b10; rdata = 9'h190;
        wait_tv(100, found);
        checks++; assert (found && t_ack === 2'b10 && t_temp === 9'h190) else begin errors++; $error("FAIL late_second: got %0b/%0h/%0h want 1/2/190", found, t_ack, t_temp); end

        // Timeout: READ never completes
        REQ = 2'b01; drop_aa = 1'b1; rdata = 9'h0A5;
        #1 base_ack = ack_cnt;
        wait_strobe(10, found);
        wait_strobe(100, found);
        checks++; assert (found && s_cmd === 8'hAA) else begin errors++; $error("FAIL to_read: got %0b/%0h want 1/aa", found, s_cmd); end
        aa_at = s_at;
        while (cyc < aa_at + 99) @(negedge CLK_IN);
        checks++; assert (ERR === 1'b0) else begin errors++; $error("FAIL err_early: got %0b want 0", ERR); end
        @(negedge CLK_IN);
        checks++; assert (ERR === 1'b1) else begin errors++; $error("FAIL err_set: got %0b want 1", ERR); end
        drop_aa = 1'b0;
        #1;
        checks++; assert (ack_cnt === base_ack) else begin errors++; $error("FAIL to_no_ack: got %0d want %0d", ack_cnt, base_ack); end
        checks++; assert (TEMP === 9'h190) else begin errors++; $error("FAIL to_temp_hold: got %0h want 190", TEMP); end
        wait_tv(200, found);
        checks++; assert (found && t_ack === 2'b01 && t_temp === 9'h0A5 && t_err === 1'b1) else begin errors++; $error("FAIL to_recover: got %0b/%0h/%0h/%0b want 1/1/0a5/1", found, t_ack, t_temp, t_err); end
        REQ = 2'b00;

        // Reset mid-WAIT
        wait_strobe(200, found);
        checks++; assert (found && s_cmd === 8'hEE) else begin errors++; $error("FAIL pre_rst_conv: got %0b/%0h want 1/ee", found, s_cmd); end
        repeat (15) @(negedge CLK_IN);
        CLR_N = 1'b0;
        #1;
        checks++; assert ({ACK, TEMP, TEMP_VALID, ERR} === 13'h0) else begin errors++; $error("FAIL rst2_outs: got %0h want 0", {ACK, TEMP, TEMP_VALID, ERR}); end
        checks++; assert ({ENG_START, ENG_CMD, ENG_WR, ENG_WDATA, ENG_RD} === 19'h0) else begin errors++; $error("FAIL rst2_eng: got %0h want 0", {ENG_START, ENG_CMD, ENG_WR, ENG_WDATA, ENG_RD}); end
        repeat (3) @(negedge CLK_IN);
        CLR_N = 1'b1; rel = cyc;
        wait_strobe(5, found);
        checks++; assert (found && {s_cmd, s_wr, s_wdata} === {8'h0C, 1'b1, 8'h02} && s_at === rel + 1) else begin errors++; $error("FAIL rst2_cfg: got %0b/%0h/%0b/%0h at %0d want 1/0c/1/02 at %0d", found, s_cmd, s_wr, s_wdata, s_at, rel + 1); end
        wait_tv(300, found);
        checks++; assert (found && t_temp === 9'h0A5 && t_ack === 2'b00 && t_err === 1'b0) else begin errors++; $error("FAIL rst2_poll: got %0b/%0h/%0h/%0b want 1/0a5/0/0", found, t_temp, t_ack, t_err); end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
